// File: rtl/soc_sram_responder.sv
// Slave side of the CPU inst/data SRAM-like ports: one unified word RAM
// shared by both ports, plus an LED/switch/timer/interrupt MMIO window.
module soc_sram_responder #(
    parameter int          ADDR_W    = 14,
    parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_en,
    input  logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [15:0] switch_in,
    output logic [15:0] led_out,
    output logic        int_out
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] i_idx;
    logic [ADDR_W-1:0] d_idx;
    logic [13:0]       off;
    logic              is_mmio;
    logic              d_wr;
    logic              ram_wr;
    logic              mmio_wr;
    logic              sel_led;
    logic              sel_sw;
    logic              sel_tmr;
    logic              sel_int;
    logic [15:0]       sw_q;
    logic [31:0]       timer;
    logic [31:0]       mmio_rd;
    logic [31:0]       led_wr;
    logic [31:0]       tmr_wr;
    logic [31:0]       ram_wr_word;

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] nw,
        input logic [3:0]  be
    );
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = be[i] ? nw[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    assign i_idx   = inst_sram_addr[ADDR_W+1:2];
    assign d_idx   = data_sram_addr[ADDR_W+1:2];
    assign off     = data_sram_addr[15:2];
    assign is_mmio = data_sram_addr[31:16] == MMIO_BASE[31:16];
    assign d_wr    = data_sram_en && (data_sram_wen != 4'b0);
    assign ram_wr  = d_wr && !is_mmio;
    assign mmio_wr = d_wr && is_mmio;

    assign sel_led = off == 14'h0;
    assign sel_sw  = off == 14'h1;
    assign sel_tmr = off == 14'h2;
    assign sel_int = off == 14'h3;

    assign led_wr      = merge({16'b0, led_out}, data_sram_wdata, data_sram_wen);
    assign tmr_wr      = merge(timer, data_sram_wdata, data_sram_wen);
    assign ram_wr_word = merge(mem[d_idx], data_sram_wdata, data_sram_wen);

    wire unused_ok = ^{inst_sram_addr[31:ADDR_W+2], inst_sram_addr[1:0],
                       data_sram_addr[1:0], led_wr[31:16]};

    always_comb begin
        mmio_rd = 32'h0;
        unique case (1'b1)
            sel_led: mmio_rd = {16'b0, led_out};
            sel_sw:  mmio_rd = {16'b0, sw_q};
            sel_tmr: mmio_rd = timer;
            sel_int: mmio_rd = {31'b0, int_out};
            default: mmio_rd = 32'h0;
        endcase
    end

    // RAM is not reset; resetn only gates writes
    always_ff @(posedge clk) begin
        if (resetn && ram_wr)
            mem[d_idx] <= ram_wr_word;
    end

    // Reads sample mem before this edge's write lands (read-before-write)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_sram_rdata <= 32'h0;
            data_sram_rdata <= 32'h0;
            led_out         <= 16'h0;
            int_out         <= 1'b0;
            sw_q            <= 16'h0;
            timer           <= 32'h0;
        end else begin
            sw_q <= switch_in;
            if (inst_sram_en)
                inst_sram_rdata <= mem[i_idx];
            if (data_sram_en)
                data_sram_rdata <= is_mmio ? mmio_rd : mem[d_idx];
            if (mmio_wr && sel_led)
                led_out <= led_wr[15:0];
            if (mmio_wr && sel_int && data_sram_wen[0])
                int_out <= data_sram_wdata[0];
            timer <= (mmio_wr && sel_tmr) ? tmr_wr : timer + 32'd1;
        end
    end

endmodule

// File: tb/tb_soc_sram_responder.sv
// Scoreboard bench for soc_sram_responder: randomized and directed
// traffic checked against a word-level reference model.
module tb_soc_sram_responder;

    localparam int          ADDR_W = 14;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam logic [31:0] MB     = 32'hBFAF_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [15:0] switch_in;
    logic [15:0] led_out;
    logic        int_out;

    always #5 clk = ~clk;

    soc_sram_responder #(.ADDR_W(ADDR_W), .MMIO_BASE(MB)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .switch_in       (switch_in),
        .led_out         (led_out),
        .int_out         (int_out)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] qi[$];
    logic [31:0] qd[$];

    // Reference model state
    logic [31:0] ram_m [int unsigned];
    logic [15:0] led_m;
    logic        int_m;
    logic [15:0] sw_m;
    logic [15:0] sw_drv;
    logic [31:0] t_ref;
    int unsigned e_ref;
    int unsigned ecnt = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] o,
                                           input logic [31:0] n,
                                           input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = be[i] ? n[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    function automatic int unsigned widx(input logic [31:0] a);
        return (a >> 2) % DEPTH;
    endfunction

    // Timer seen at edge e (before that edge's increment) is t_ref + (e - e_ref)
    function automatic logic [31:0] tval();
        return t_ref + 32'(ecnt - e_ref);
    endfunction

    function automatic void model_reset();
        led_m = 16'h0;
        int_m = 1'b0;
        sw_m  = 16'h0;
        t_ref = 32'h0;
        e_ref = ecnt;
    endfunction

    // One clock of stimulus; expected read results are queued before the edge
    task automatic cyc(input logic ie, input logic [31:0] ia, input logic de,
                       input logic [3:0] dw, input logic [31:0] da,
                       input logic [31:0] dd);
        logic [31:0] old;
        logic [31:0] tmp;
        logic        mm;
        int unsigned off;
        @(negedge clk);
        resetn          = 1'b1;
        inst_sram_en    = ie;
        inst_sram_addr  = ia;
        data_sram_en    = de;
        data_sram_wen   = dw;
        data_sram_addr  = da;
        data_sram_wdata = dd;
        switch_in       = sw_drv;
        if (ie)
            qi.push_back(ram_m[widx(ia)]);
        mm  = (da >> 16) == (MB >> 16);
        off = (da & 32'hFFFF) >> 2;
        if (de) begin
            if (mm) begin
                case (off)
                    0: old = {16'h0, led_m};
                    1: old = {16'h0, sw_m};
                    2: old = tval();
                    3: old = {31'h0, int_m};
                    default: old = 32'h0;
                endcase
            end else begin
                old = ram_m[widx(da)];
            end
            qd.push_back(old);
            if (dw != 4'h0) begin
                if (mm) begin
                    case (off)
                        0: begin
                            tmp   = bmerge({16'h0, led_m}, dd, dw);
                            led_m = tmp[15:0];
                        end
                        2: begin
                            t_ref = bmerge(old, dd, dw);
                            e_ref = ecnt + 1;
                        end
                        3: if (dw[0]) int_m = dd[0];
                        default: ;
                    endcase
                end else begin
                    ram_m[widx(da)] = bmerge(old, dd, dw);
                end
            end
        end
        sw_m = sw_drv;
        ecnt++;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] d);
        cyc(1'b0, 32'h0, 1'b1, be, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(1'b0, 32'h0, 1'b1, 4'h0, a, 32'h0);
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops an expectation on every enabled port, otherwise checks hold
    initial begin
        logic [31:0] last_i;
        logic [31:0] last_d;
        logic        ie;
        logic        de;
        logic        rs;
        last_i = 32'h0;
        last_d = 32'h0;
        forever begin
            @(posedge clk);
            ie = inst_sram_en;
            de = data_sram_en;
            rs = resetn;
            #1;
            if (!rs) begin
                last_i = 32'h0;
                last_d = 32'h0;
            end else begin
                if (ie) begin
                    if (qi.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL inst_queue: got empty expected entry");
                    end else begin
                        last_i = qi.pop_front();
                    end
                end
                if (de) begin
                    if (qd.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL data_queue: got empty expected entry");
                    end else begin
                        last_d = qd.pop_front();
                    end
                end
                check("inst_rdata", inst_sram_rdata, last_i);
                check("data_rdata", data_sram_rdata, last_d);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ia;
        logic [31:0] da;
        logic [3:0]  be;
        logic        mm;
        resetn          = 1'b0;
        inst_sram_en    = 1'b0;
        inst_sram_addr  = 32'h0;
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'h0;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
        switch_in       = 16'h0;
        sw_drv          = 16'h0;
        repeat (3) @(posedge clk);
        model_reset();

        // Timer counts from 0 right after reset
        rd(MB + 32'h8);
        rd(MB + 32'h8);
        rd(MB + 32'h8);

        for (int i = 0; i < 32; i++)
            wr(32'(i) << 2, 4'hF, $urandom);
        wr(32'h100, 4'hF, $urandom);

        // Byte-enable merge
        wr(32'h100, 4'hF, 32'h1122_3344);
        wr(32'h100, 4'b0101, 32'hAABB_CCDD);
        rd(32'h100);

        // Same-word collision
        wr(32'h40, 4'hF, 32'h1);
        cyc(1'b1, 32'h40, 1'b1, 4'hF, 32'h40, 32'h2);
        cyc(1'b1, 32'h40, 1'b0, 4'h0, 32'h0, 32'h0);

        // Address wrap onto word 0
        wr(32'h0001_0000, 4'hF, 32'h0000_CAFE);
        rd(32'h0);
        cyc(1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);

        // MMIO registers
        wr(MB, 4'hF, 32'h1234_5678);
        after_edge();
        check("led_out", {16'h0, led_out}, 32'h0000_5678);
        rd(MB);
        sw_drv = 16'hA5A5;
        idle();
        rd(MB + 32'h4);
        wr(MB + 32'h4, 4'hF, 32'hFFFF_FFFF);
        rd(MB + 32'h4);
        wr(MB + 32'h8, 4'hF, 32'hFFFF_FFFE);
        idle();
        rd(MB + 32'h8);
        rd(MB + 32'h8);

        // Interrupt register and unmapped offset
        wr(MB + 32'hC, 4'hF, 32'h1);
        after_edge();
        check("int_set", {31'h0, int_out}, 32'h1);
        wr(MB + 32'hC, 4'hF, 32'h0);
        after_edge();
        check("int_clr", {31'h0, int_out}, 32'h0);
        wr(MB + 32'hC, 4'h1, 32'h1);
        wr(MB + 32'h10, 4'hF, 32'hFFFF_FFFF);
        after_edge();
        check("int_keep", {31'h0, int_out}, 32'h1);
        check("led_keep", {16'h0, led_out}, 32'h0000_5678);
        rd(MB + 32'h10);
        rd(MB);
        rd(MB + 32'hC);

        // Reset in the middle of a read
        @(negedge clk);
        inst_sram_en   = 1'b1;
        inst_sram_addr = 32'h100;
        data_sram_en   = 1'b1;
        data_sram_wen  = 4'h0;
        data_sram_addr = 32'h100;
        #2 resetn = 1'b0;
        #1;
        check("rst_inst_rdata", inst_sram_rdata, 32'h0);
        check("rst_data_rdata", data_sram_rdata, 32'h0);
        check("rst_led", {16'h0, led_out}, 32'h0);
        check("rst_int", {31'h0, int_out}, 32'h0);
        repeat (2) @(posedge clk);
        model_reset();
        sw_drv = 16'h0;
        rd(MB + 32'h8);
        rd(MB + 32'h8);
        rd(MB + 32'h8);
        rd(32'h100);

        // Randomized traffic over a pre-initialised pool of words
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0)
                sw_drv = 16'($urandom);
            ia = ($urandom << (ADDR_W + 2)) | (32'($urandom_range(0, 31)) << 2)
                 | 32'($urandom_range(0, 3));
            mm = $urandom_range(0, 3) == 0;
            if (mm)
                da = MB | (32'($urandom_range(0, 5)) << 2)
                     | 32'($urandom_range(0, 3));
            else
                da = (32'($urandom_range(0, 255)) << (ADDR_W + 2))
                     | (32'($urandom_range(0, 31)) << 2)
                     | 32'($urandom_range(0, 3));
            be = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom_range(1, 15));
            cyc(1'($urandom_range(0, 1)), ia, 1'($urandom_range(0, 1)), be, da,
                $urandom);
        end
        idle();
        idle();
        after_edge();
        check("queues_drained", 32'(qi.size() + qd.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
